// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: one request at a time, fixed latency, byte/half/word with error flagging
// Optional feature macro: DMEM_OOR_BADBAD_EN (range check, out-of-range loads return 32'hbadbadff)

module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          enter_resp;
    logic          accept;

    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_we;
    logic [1:0]    lat_size;
    logic          lat_unsigned;

    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_we;
    logic [1:0]    cur_size;
    logic          cur_unsigned;

    logic [AW-1:0] widx;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   byte_shift;
    logic [31:0]   half_shift;
    logic [31:0]   ld_data;
    logic [31:0]   rdata_next;
    logic          misaligned;
    logic          out_of_range;
    logic          err_next;

    logic [31:0]   mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_ready && req_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; enter_resp marks the edge on which the access is performed
    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fields of the access being performed: live request when LATENCY is 1, latched copy otherwise
    always_comb begin
        if (state == IDLE) begin
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
            cur_we       = req_we;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
        end else begin
            cur_addr     = lat_addr;
            cur_wdata    = lat_wdata;
            cur_we       = lat_we;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
        end
    end

    // Error classification; misalignment wins over range so it forces zero data
    always_comb begin
        misaligned = (cur_size == 2'b11) ||
                     ((cur_size == 2'b01) && cur_addr[0]) ||
                     ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`ifdef DMEM_OOR_BADBAD_EN
        out_of_range = (cur_addr < BASE_ADDR) || ((cur_addr - BASE_ADDR) >= SPAN);
`else
        out_of_range = 1'b0;
`endif
        err_next = misaligned || out_of_range;
    end

    // Word read, lane extraction with extension, and read-modify-write merge for narrow stores
    always_comb begin
        widx       = AW'((cur_addr - BASE_ADDR) >> 2);
        rd_word    = mem[widx];
        byte_shift = rd_word >> {cur_addr[1:0], 3'b000};
        half_shift = rd_word >> {cur_addr[1], 4'b0000};
        ld_data    = 32'h0;
        wr_word    = rd_word;
        case (cur_size)
            2'b00: begin
                ld_data = cur_unsigned ? {24'h0, byte_shift[7:0]}
                                       : {{24{byte_shift[7]}}, byte_shift[7:0]};
                wr_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
            end
            2'b01: begin
                ld_data = cur_unsigned ? {16'h0, half_shift[15:0]}
                                       : {{16{half_shift[15]}}, half_shift[15:0]};
                wr_word[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
            end
            2'b10: begin
                ld_data = rd_word;
                wr_word = cur_wdata;
            end
            default: begin
                ld_data = 32'h0;
                wr_word = rd_word;
            end
        endcase

        if (misaligned) begin
            rdata_next = 32'h0;
        end else if (out_of_range) begin
            rdata_next = cur_we ? 32'h0 : 32'hbadbadff;
        end else if (cur_we) begin
            rdata_next = 32'h0;
        end else begin
            rdata_next = ld_data;
        end
    end

    // Storage commit on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && cur_we && !err_next) begin
            mem[widx] <= wr_word;
        end
    end

    // Request latch, latency counter and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            cnt          <= '0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_we       <= req_we;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                cnt          <= (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (enter_resp) begin
                resp_rdata <= rdata_next;
                resp_err   <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized self-checking bench for dmem_responder

module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    bit [31:0]   mm [int];
    logic [31:0] got_rd;
    logic [31:0] exp_rd;
    logic        got_err;
    logic        exp_err;
    int          got_edges;

    dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a sparse word map, lanes handled with masks and shifts
    function automatic void model(input logic [31:0] a, input bit we, input logic [31:0] wd,
                                  input logic [1:0] sz, input bit uns,
                                  output logic [31:0] rd, output logic er);
        int                nb   = 1 << sz;
        int                sh   = 8 * int'(a % 4);
        logic [31:0]       off  = a - BASE;
        int                idx  = int'((off >> 2) % DEPTH);
        longint unsigned   lm   = (64'd1 << (8 * nb)) - 64'd1;
        longint unsigned   w;
        longint unsigned   v;
        bit                mis  = (sz == 2'b11) || ((a % nb) != 0);
        bit                oor  = 1'b0;
`ifdef DMEM_OOR_BADBAD_EN
        oor = (a < BASE) || (off >= 32'(4 * DEPTH));
`endif
        er = mis || oor;
        rd = 32'h0;
        if (mis) return;
        if (oor) begin
            if (!we) rd = 32'hbadbadff;
            return;
        end
        w = mm.exists(idx) ? 64'(mm[idx]) : 64'd0;
        if (we) begin
            v = (w & ~(lm << sh)) | ((64'(wd) & lm) << sh);
            mm[idx] = v[31:0];
        end else begin
            v = (w >> sh) & lm;
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~lm;
            rd = v[31:0];
        end
    endfunction

    task automatic xact(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input logic [1:0] sz, input bit uns);
        @(negedge clk);
        req_addr = a; req_we = we; req_wdata = wd; req_size = sz; req_unsigned = uns;
        req_valid = 1'b1;
        @(posedge clk);
        got_edges = 1;
        #1 req_valid = 1'b0;
        while (resp_valid !== 1'b1 && got_edges < 50) begin
            @(posedge clk);
            #1 got_edges++;
        end
        got_rd  = resp_rdata;
        got_err = resp_err;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input bit we, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns);
        model(a, we, wd, sz, uns, exp_rd, exp_err);
        xact(a, we, wd, sz, uns);
    endtask

    initial begin
        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk) reset = 1'b0;

        // Word store then load, latency from acceptance edge
        run(BASE + 8, 1, 32'hdeadbeef, 2'b10, 0);
        check("sw8_edges", got_edges, LAT);
        check("sw8_err", 32'(got_err), 32'd0);
        check("sw8_rdata", got_rd, 32'h0);
        run(BASE + 8, 0, 32'h0, 2'b10, 0);
        check("lw8_edges", got_edges, LAT);
        check("lw8_rdata", got_rd, 32'hdeadbeef);
        check("lw8_err", 32'(got_err), 32'd0);

        // Byte lane store and signed/unsigned byte loads
        run(BASE + 9, 1, 32'h12345680, 2'b00, 0);
        check("sb9_err", 32'(got_err), 32'd0);
        run(BASE + 9, 0, 32'h0, 2'b00, 0);
        check("lb9", got_rd, 32'hffffff80);
        run(BASE + 9, 0, 32'h0, 2'b00, 1);
        check("lbu9", got_rd, 32'h00000080);
        run(BASE + 8, 0, 32'h0, 2'b10, 1);
        check("lw8_after_sb", got_rd, 32'hdead80ef);

        // Misaligned accesses; failed store leaves memory alone
        run(BASE + 4, 1, 32'h11223344, 2'b10, 0);
        run(BASE + 3, 0, 32'h0, 2'b01, 0);
        check("lh3_err", 32'(got_err), 32'd1);
        check("lh3_rdata", got_rd, 32'h0);
        run(BASE + 6, 1, 32'haaaaaaaa, 2'b10, 0);
        check("sw6_err", 32'(got_err), 32'd1);
        run(BASE + 4, 0, 32'h0, 2'b10, 0);
        check("lw4_unchanged", got_rd, 32'h11223344);
        run(BASE + 4, 0, 32'h0, 2'b11, 0);
        check("rsvd_err", 32'(got_err), 32'd1);
        check("rsvd_rdata", got_rd, 32'h0);

`ifdef DMEM_OOR_BADBAD_EN
        run(BASE - 4, 0, 32'h0, 2'b10, 0);
        check("oor_err", 32'(got_err), 32'd1);
        check("oor_rdata", got_rd, 32'hbadbadff);
        run(BASE - 3, 0, 32'h0, 2'b10, 0);
        check("oor_mis_rdata", got_rd, 32'h0);
`else
        run(BASE + 32'(4 * DEPTH), 1, 32'hcafef00d, 2'b10, 0);
        check("wrap_sw_err", 32'(got_err), 32'd0);
        run(BASE, 0, 32'h0, 2'b10, 0);
        check("wrap_lw", got_rd, 32'hcafef00d);
        check("wrap_lw_err", 32'(got_err), 32'd0);
`endif

        // Back-pressure: response held stable, extra request ignored
        @(negedge clk);
        req_addr = BASE + 8; req_we = 1'b0; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clk);
        got_edges = 1;
        #1 req_valid = 1'b0;
        while (resp_valid !== 1'b1 && got_edges < 50) begin
            @(posedge clk);
            #1 got_edges++;
        end
        check("bp_edges", got_edges, LAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 8; req_wdata = 32'h0; req_size = 2'b10;
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'hdead80ef);
            check("bp_err", 32'(resp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        run(BASE + 8, 0, 32'h0, 2'b10, 0);
        check("bp_extra_ignored", got_rd, 32'hdead80ef);

        // Reset in WAIT of a store: immediate reset outputs, no response, no write
        @(negedge clk);
        req_addr = BASE + 8; req_we = 1'b1; req_wdata = 32'h12345678; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("wait_req_ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'h0);
        check("mid_rst_err", 32'(resp_err), 32'd0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("post_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        run(BASE + 8, 0, 32'h0, 2'b10, 0);
        check("post_rst_old_word", got_rd, 32'hdead80ef);

        // Randomized traffic over a seeded window against the reference model
        for (int i = 16; i < 32; i++) begin
            run(BASE + 32'(4 * i), 1, $urandom, 2'b10, 0);
            check("seed_err", 32'(got_err), 32'(exp_err));
        end
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = BASE + 32'(4 * $urandom_range(16, 31)) + 32'($urandom_range(0, 3));
            run(a, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            check("rnd_rdata", got_rd, exp_rd);
            check("rnd_err", 32'(got_err), 32'(exp_err));
            check("rnd_edges", got_edges, LAT);
        end
        for (int i = 16; i < 32; i++) begin
            run(BASE + 32'(4 * i), 0, 32'h0, 2'b10, 0);
            check("final_word", got_rd, exp_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
